// File: rtl/mix_sequencer_pkg.sv
// Shared phase and mode codes for the mixing datapath sequencer.
// Latency: n/a (constants and pure helpers only); backpressure: n/a.
package mix_sequencer_pkg;

    localparam int STATE_LEN = 2;
    localparam int MODE_LEN  = 2;

    localparam logic [STATE_LEN-1:0] IDLE = 2'd0;
    localparam logic [STATE_LEN-1:0] MIX1 = 2'd1;
    localparam logic [STATE_LEN-1:0] MIX2 = 2'd2;
    localparam logic [STATE_LEN-1:0] MIX3 = 2'd3;

    localparam logic [MODE_LEN-1:0] FORWARD  = 2'd0;
    localparam logic [MODE_LEN-1:0] BACKWARD = 2'd1;
    localparam logic [MODE_LEN-1:0] GEN_SIMI = 2'd2;
    localparam logic [MODE_LEN-1:0] GEN_NEW  = 2'd3;

    // GEN_NEW jumps straight to the random-vector phase.
    function automatic logic skips_mix(input logic [MODE_LEN-1:0] m);
        return m == GEN_NEW;
    endfunction

    // GEN_SIMI fetches a random vector after the last MIX2 pass.
    function automatic logic rand_after_mix2(input logic [MODE_LEN-1:0] m);
        return m == GEN_SIMI;
    endfunction

endpackage

// File: rtl/mix_sequencer_phase_timer.sv
// Per-phase wait counter; expired is high on the TIMEOUT-th cycle of a phase.
// Latency: clear takes effect next cycle; backpressure: none, saturates at the limit.
module mix_sequencer_phase_timer #(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] ONE   = TO_W'(1);

    logic [TO_W-1:0] cnt;

    // cnt holds the number of completed cycles in the current phase.
    assign expired = en && (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/mix_sequencer.sv
// Steps each job through EMB -> MIX1 -> MIX2 x N -> (RAND) -> MIX3 and drives the phase code.
// Latency: one cycle per accepted handshake; backpressure: waits on valids, bounded by TIMEOUT.
module mix_sequencer
    import mix_sequencer_pkg::*;
#(
    parameter int MIX2_REPS = 1,
    parameter int TIMEOUT   = 1023,
    parameter int TO_W      = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [MODE_LEN-1:0]  mode,
    input  logic                 valid_emb,
    input  logic                 valid_mix,
    input  logic                 valid_rand,
    output logic [STATE_LEN-1:0] state,
    output logic                 rand_req,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [3:0]           rep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMB,
        S_MIX1,
        S_MIX2,
        S_RAND,
        S_MIX3
    } fsm_t;

    localparam logic [3:0] LAST_REP = 4'(MIX2_REPS - 1);

    fsm_t                fsm_q;
    fsm_t                fsm_d;
    fsm_t                adv;
    logic [MODE_LEN-1:0] mode_q;
    logic [MODE_LEN-1:0] mode_d;
    logic [3:0]          rep_q;
    logic [3:0]          rep_d;
    logic                fresh_q;
    logic                hit;
    logic                repeat_pass;
    logic                done_d;
    logic                err_d;
    logic                done_q;
    logic                err_q;
    logic                mix_ok;
    logic                expired;
    logic                tmr_clr;

    // A completion flag still high from the previous phase must not count twice.
    assign mix_ok = valid_mix && !fresh_q;

    always_comb begin
        hit = 1'b0;
        adv = S_IDLE;
        case (fsm_q)
            S_EMB: begin
                hit = valid_emb;
                adv = S_MIX1;
            end
            S_MIX1: begin
                hit = mix_ok;
                adv = S_MIX2;
            end
            S_MIX2: begin
                hit = mix_ok;
                if (rep_q != LAST_REP) begin
                    adv = S_MIX2;
                end else if (rand_after_mix2(mode_q)) begin
                    adv = S_RAND;
                end else begin
                    adv = S_MIX3;
                end
            end
            S_RAND: begin
                hit = valid_rand;
                adv = S_MIX3;
            end
            S_MIX3: begin
                hit = mix_ok;
                adv = S_IDLE;
            end
            default: begin
                hit = 1'b0;
                adv = S_IDLE;
            end
        endcase
    end

    always_comb begin
        fsm_d       = fsm_q;
        mode_d      = mode_q;
        rep_d       = rep_q;
        repeat_pass = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        if (fsm_q == S_IDLE) begin
            if (start) begin
                mode_d = mode;
                rep_d  = 4'd0;
                fsm_d  = skips_mix(mode) ? S_RAND : S_EMB;
            end
        end else if (abort) begin
            fsm_d = S_IDLE;
        end else if (hit) begin
            fsm_d  = adv;
            done_d = (fsm_q == S_MIX3);
            if (fsm_q == S_MIX2 && adv == S_MIX2) begin
                rep_d       = rep_q + 4'd1;
                repeat_pass = 1'b1;
            end
        end else if (expired) begin
            fsm_d = S_IDLE;
            err_d = 1'b1;
        end
    end

    assign tmr_clr = (fsm_d != fsm_q) || repeat_pass || (fsm_q == S_IDLE);

    mix_sequencer_phase_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_phase_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (busy),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            mode_q  <= FORWARD;
            rep_q   <= 4'd0;
            fresh_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            mode_q  <= mode_d;
            rep_q   <= rep_d;
            fresh_q <= (fsm_d != fsm_q) || repeat_pass;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state = IDLE;
        case (fsm_q)
            S_MIX1:  state = MIX1;
            S_MIX2:  state = MIX2;
            S_RAND:  state = MIX3;
            S_MIX3:  state = MIX3;
            default: state = IDLE;
        endcase
    end

    assign busy     = (fsm_q != S_IDLE);
    assign rand_req = (fsm_q == S_RAND) && fresh_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rep_cnt  = rep_q;

endmodule
